// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART transmit feeder.
package uart_pkg;

  localparam int BYTE_W           = 8;
  localparam int FRAME_CYCLES_DEF = 10;
  localparam int GUARD_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    PULSE = 2'd2,
    WAIT  = 2'd3
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular byte FIFO with sticky overflow; a push into a full queue is
// still accepted when a pop happens on the same edge.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [BYTE_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [PTR_W:0]    count,
  output logic              overflow
);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W:0]    count_reg;
  logic              overflow_reg;
  logic              push_ok;
  logic              pop;

  assign full     = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign overflow = overflow_reg;
  assign rd_data  = mem[rd_ptr_reg];

  assign pop     = rd_en && !empty;
  assign push_ok = wr_en && (!full || pop);

  // Storage carries no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (push_ok && !pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (pop && !push_ok) begin
        count_reg <= count_reg - 1'b1;
      end
      if (wr_en && !push_ok) begin
        overflow_reg <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Drains queued bytes into the UART transmitter: present byte, strobe
// btn_n low, then wait out the frame plus guard time.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int PTR_W        = 3,
  parameter int PULSE_CYCLES = 1,
  parameter int FRAME_CYCLES = FRAME_CYCLES_DEF,
  parameter int GUARD_CYCLES = GUARD_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic [PTR_W:0]    count,
  output logic              overflow,
  output logic [BYTE_W-1:0] tx_data,
  output logic              btn_n,
  output logic              busy
);

  localparam int WAIT_LEN = FRAME_CYCLES + GUARD_CYCLES;
  localparam int CNT_W    = $clog2(max_int(WAIT_LEN, PULSE_CYCLES) + 1);

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [BYTE_W-1:0] tx_data_reg;
  logic [BYTE_W-1:0] fifo_rd_data;
  logic              btn_n_reg;
  logic              busy_reg;
  logic              pop;

  assign pop = (state_reg == IDLE) && !empty;

  sync_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .rd_data  (fifo_rd_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      tx_data_reg <= '0;
      btn_n_reg   <= 1'b1;
      busy_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!empty) begin
            tx_data_reg <= fifo_rd_data;
            busy_reg    <= 1'b1;
            state_reg   <= LOAD;
          end
        end
        LOAD: begin
          btn_n_reg <= 1'b0;
          cnt_reg   <= CNT_W'(PULSE_CYCLES - 1);
          state_reg <= PULSE;
        end
        PULSE: begin
          if (cnt_reg == '0) begin
            btn_n_reg <= 1'b1;
            cnt_reg   <= CNT_W'(WAIT_LEN - 1);
            state_reg <= WAIT;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        WAIT: begin
          // Never cut a frame short; the next pop happens only from IDLE.
          if (cnt_reg == '0) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign tx_data = tx_data_reg;
  assign btn_n   = btn_n_reg;
  assign busy    = busy_reg;

endmodule
